// File: rtl/nx_stream_wrr_arbiter.sv
// nx_stream_wrr_arbiter: weighted round-robin scheduler merging several message streams into one registered stream
module nx_stream_wrr_arbiter #(
    parameter int STREAMS = 4,
    parameter int WEIGHT_WIDTH = 4,
    parameter int MESSAGE_WIDTH = 32,
    localparam int OW = (STREAMS > 1) ? $clog2(STREAMS) : 1
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [STREAMS*WEIGHT_WIDTH-1:0]  i_weights,
    input  logic                             i_weight_load,
    input  logic [STREAMS*MESSAGE_WIDTH-1:0] i_inbound_data,
    input  logic [STREAMS-1:0]               i_inbound_valid,
    output logic [STREAMS-1:0]               o_inbound_ready,
    output logic [MESSAGE_WIDTH-1:0]         o_outbound_data,
    output logic                             o_outbound_valid,
    input  logic                             i_outbound_ready,
    output logic [OW-1:0]                    o_owner,
    output logic                             o_busy
);
    typedef enum logic {IDLE, SERVE} state_t;
    state_t state;
    logic [OW-1:0] ptr, owner, sel, idx, nxt_owner;
    logic [WEIGHT_WIDTH-1:0] credit;
    logic [STREAMS-1:0][WEIGHT_WIDTH-1:0] weights_q;
    logic [STREAMS-1:0][MESSAGE_WIDTH-1:0] data_a;
    logic found, can_accept, xfer;
    assign data_a = i_inbound_data;
    assign can_accept = !o_outbound_valid || i_outbound_ready;
    assign xfer = state == SERVE && i_inbound_valid[owner] && can_accept;
    assign nxt_owner = (owner == OW'(STREAMS - 1)) ? '0 : owner + 1'b1;
    assign o_inbound_ready = (state == SERVE && can_accept) ? STREAMS'(1) << owner : '0;
    assign o_owner = owner;
    assign o_busy = state == SERVE;
    // Scan downward so the candidate closest to ptr is the one left in sel.
    always_comb begin
        found = 1'b0;
        sel = ptr;
        idx = ptr;
        for (int k = STREAMS - 1; k >= 0; k--) begin
            idx = OW'((int'(ptr) + k) % STREAMS);
            if (i_inbound_valid[idx] && weights_q[idx] != '0) begin
                found = 1'b1;
                sel = idx;
            end
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            ptr <= '0;
            owner <= '0;
            credit <= '0;
            weights_q <= {STREAMS{WEIGHT_WIDTH'(1)}};
            o_outbound_valid <= 1'b0;
            o_outbound_data <= '0;
        end else begin
            if (i_weight_load) weights_q <= i_weights;
            o_outbound_valid <= xfer || (o_outbound_valid && !i_outbound_ready);
            if (xfer) o_outbound_data <= data_a[owner];
            if (state == IDLE) begin
                if (found) begin
                    owner <= sel;
                    credit <= weights_q[sel];
                    state <= SERVE;
                end
            end else if (can_accept) begin
                credit <= xfer ? credit - WEIGHT_WIDTH'(1) : '0;
                if (!xfer || credit == WEIGHT_WIDTH'(1)) begin
                    state <= IDLE;
                    ptr <= nxt_owner;
                end
            end
        end
    end
endmodule

// File: tb/tb_nx_stream_wrr_arbiter.sv
// tb_nx_stream_wrr_arbiter: directed checks of burst order, stalls, yield, weight reload and async reset
module tb_nx_stream_wrr_arbiter;
    localparam int N = 4, WW = 4, MW = 32;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [N*WW-1:0] weights = '0;
    logic load = 1'b0;
    logic [N*MW-1:0] idata;
    logic [N-1:0] ivalid = '0, iready;
    logic [MW-1:0] odata;
    logic ovalid, oready = 1'b1, busy;
    logic [1:0] owner;
    logic [15:0] seq [N];
    logic [MW-1:0] log_q [$];
    logic [MW-1:0] e [$];
    int r2cnt = 0, passed = 0, total = 0, base, r0;

    nx_stream_wrr_arbiter #(.STREAMS(N), .WEIGHT_WIDTH(WW), .MESSAGE_WIDTH(MW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_weights(weights), .i_weight_load(load),
        .i_inbound_data(idata), .i_inbound_valid(ivalid), .o_inbound_ready(iready),
        .o_outbound_data(odata), .o_outbound_valid(ovalid), .i_outbound_ready(oready),
        .o_owner(owner), .o_busy(busy));

    always #5 clk = ~clk;

    function automatic logic [MW-1:0] mk(int s, int q);
        return {12'hD00, 4'(s), 16'(q)};
    endfunction

    always_comb for (int s = 0; s < N; s++) idata[s*MW +: MW] = mk(s, int'(seq[s]));

    always @(posedge clk or negedge rst_n)
        if (!rst_n) for (int s = 0; s < N; s++) seq[s] <= '0;
        else for (int s = 0; s < N; s++) if (ivalid[s] && iready[s]) seq[s] <= seq[s] + 16'd1;

    always @(posedge clk) begin
        if (rst_n && ovalid && oready) log_q.push_back(odata);
        if (iready[2]) r2cnt++;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_log(string tag, int b);
        for (int i = 0; i < e.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), (b + i < log_q.size()) ? 64'(log_q[b + i]) : 64'hDEAD, 64'(e[i]));
    endtask

    task automatic do_reset(logic [N*WW-1:0] w, logic [N-1:0] v);
        ivalid = '0; load = 1'b0; oready = 1'b1; rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        if (w != '0) begin
            weights = w; load = 1'b1;
            step();
            load = 1'b0;
        end
        base = log_q.size();
        ivalid = v;
    endtask

    initial begin
        // 1: reset state, then unit weights rotate 0,1,2,3,0 with a bubble between grants
        do_reset('0, '0);
        chk("rst_valid", 64'(ovalid), 0);
        chk("rst_ready", 64'(iready), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_owner", 64'(owner), 0);
        chk("rst_data", 64'(odata), 0);
        ivalid = 4'hF;
        step();
        chk("t1_busy", 64'(busy), 1);
        chk("t1_ready", 64'(iready), 64'h1);
        step();
        chk("t1_ovalid", 64'(ovalid), 1);
        chk("t1_odata", 64'(odata), 64'(mk(0, 0)));
        chk("t1_busy_bubble", 64'(busy), 0);
        step();
        chk("t1_ovalid_bubble", 64'(ovalid), 0);
        chk("t1_owner1", 64'(owner), 1);
        repeat (9) step();
        e = '{mk(0, 0), mk(1, 0), mk(2, 0), mk(3, 0), mk(0, 1)};
        chk_log("t1_order", base);
        // 2: weights s0=3 s1=1 s2=0 s3=2
        do_reset(16'h2013, 4'hF);
        r0 = r2cnt;
        repeat (18) step();
        e = '{mk(0, 0), mk(0, 1), mk(0, 2), mk(1, 0), mk(3, 0), mk(3, 1), mk(0, 3), mk(0, 4), mk(0, 5)};
        chk_log("t2_order", base);
        chk("t2_ready2_count", 64'(r2cnt - r0), 0);
        // 3: outbound stall mid-burst freezes everything and keeps credit
        do_reset(16'h1114, 4'h1);
        step();
        chk("t3_busy", 64'(busy), 1);
        step();
        chk("t3_d0", 64'(odata), 64'(mk(0, 0)));
        step();
        chk("t3_d1", 64'(odata), 64'(mk(0, 1)));
        oready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("t3_hold_valid%0d", i), 64'(ovalid), 1);
            chk($sformatf("t3_hold_data%0d", i), 64'(odata), 64'(mk(0, 1)));
            chk($sformatf("t3_hold_ready%0d", i), 64'(iready), 0);
            chk($sformatf("t3_hold_busy%0d", i), 64'(busy), 1);
        end
        oready = 1'b1;
        step();
        chk("t3_d2", 64'(odata), 64'(mk(0, 2)));
        chk("t3_d2_busy", 64'(busy), 1);
        step();
        chk("t3_d3", 64'(odata), 64'(mk(0, 3)));
        chk("t3_d3_busy", 64'(busy), 0);
        // 4: s1 yields after 2 messages, next search starts at s2
        do_reset(16'h4444, 4'h2);
        step();
        chk("t4_owner1", 64'(owner), 1);
        step();
        step();
        chk("t4_d1", 64'(odata), 64'(mk(1, 1)));
        ivalid = 4'b0101;
        step();
        chk("t4_yield_busy", 64'(busy), 0);
        step();
        chk("t4_grant_busy", 64'(busy), 1);
        chk("t4_owner2", 64'(owner), 2);
        // 5: reload mid-burst only affects the next grant
        do_reset(16'h1113, 4'h3);
        step();
        chk("t5_owner0", 64'(owner), 0);
        step();
        weights = 16'h1111; load = 1'b1;
        step();
        load = 1'b0;
        repeat (12) step();
        e = '{mk(0, 0), mk(0, 1), mk(0, 2), mk(1, 0), mk(0, 3), mk(1, 1)};
        chk_log("t5_order", base);
        // 6: async reset mid-SERVE clears outputs without a clock edge
        do_reset(16'h1114, 4'h1);
        step();
        step();
        chk("t6_pre_valid", 64'(ovalid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", 64'(ovalid), 0);
        chk("t6_ready", 64'(iready), 0);
        chk("t6_busy", 64'(busy), 0);
        chk("t6_data", 64'(odata), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("t6_regrant", 64'(busy), 1);
        chk("t6_owner", 64'(owner), 0);
        step();
        chk("t6_out", 64'(odata), 64'(mk(0, 0)));
        chk("t6_unit_weight", 64'(busy), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
